mem_block_copier: RTL and testbench
===================================

Name: mem_block_copier

Overview:
- Bus initiator for `memoryController`. It drives `we`, `VecOp`, `address` and `wd`, and consumes `rd`.
- Copies a byte range from a source region (ROM image or RAM) into RAM.
- Bulk of the range moves as 192-bit vector beats; the remainder moves byte by byte with scalar accesses.
- Sits beside the core; the pipeline is stalled on `busy` while it owns the data port.

Parameters:
- DATA_W, 192, vector beat width in bits
- VEC_BYTES, 24, bytes per vector beat (DATA_W/8)
- RAM_BASE, 31000, first legal destination address
- READ_LAT, 1, cycles from a read address being presented to `mem_rd` being valid (1..4)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request pulse, sampled only in IDLE
- src_addr  in  32  byte address of first source byte
- dst_addr  in  32  byte address of first destination byte
- len_bytes  in  16  number of bytes to copy
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle pulse at transfer end
- err  out  1  valid with `done`; 1 = request rejected
- mem_we  out  1  to memoryController `we`
- mem_vecop  out  1  to memoryController `VecOp`
- mem_address  out  32  to memoryController `address`
- mem_wd  out  192  to memoryController `wd`
- mem_rd  in  192  from memoryController `rd`

Behaviour:
- **Reset**
  - Any cycle with `rst`=1: state goes to IDLE and every output register goes to 0.
  - A transfer in flight is abandoned; no further `mem_we`, and no `done`.
- **Request acceptance**
  - `start` is sampled only in IDLE; `start` while busy is ignored.
  - On accept, latch `src_ptr`, `dst_ptr`, `remain` = `len_bytes`. `busy`=1 from the next cycle through the DONE cycle inclusive.
- **Request checks**
  - If `len_bytes`=0: go to DONE with `err`=0.
  - If `dst_addr` < RAM_BASE: go to DONE with `err`=1.
  - In both cases no memory access is issued.
- **States:** IDLE, VRD, VWAIT, VWR, SRD, SWAIT, SWR, DONE.
- **Beat selection** (after accept or after any write): `remain` >= VEC_BYTES -> VRD; 0 < `remain` < VEC_BYTES -> SRD; `remain`=0 -> DONE.
- **VRD** (1 cycle): `mem_address`=`src_ptr`, `mem_vecop`=1, `mem_we`=0.
- **VWAIT** (READ_LAT cycles)
  - Address and `mem_vecop` are held.
  - `mem_rd` is captured into `beat_buf` at the end of the last VWAIT cycle.
- **VWR** (1 cycle)
  - Drives `mem_address`=`dst_ptr`, `mem_vecop`=1, `mem_we`=1, `mem_wd`=`beat_buf`.
  - Then `src_ptr` += 24, `dst_ptr` += 24, `remain` -= 24.
- **SRD / SWAIT / SWR:** same sequence with `mem_vecop`=0.
  - Only `mem_rd[7:0]` is captured.
  - `mem_wd` = {184'b0, byte}.
  - Pointers advance by 1; `remain` decrements by 1.
- **Beat cost:** READ_LAT+2 cycles. For READ_LAT=1 that is 3 cycles per beat.
- **DONE** (1 cycle): `done`=1, `err` as decided; then IDLE. `err` is 0 whenever `done`=0.
- **Idle bus:** outside VWR/SWR `mem_we`=0. In IDLE and DONE, `mem_vecop`, `mem_address` and `mem_wd` are 0.
- **Arithmetic:** pointers are 32-bit and wrap modulo 2^32 with no error. Overlap between source and destination is not detected; the copy runs in ascending order.

Optional Feature:
- Macro: `BLKCOPY_FILL_EN`.
- **When defined**
  - Adds ports `fill` (in, 1) and `fill_byte` (in, 8), latched with `start`.
  - If `fill`=1, all read states are skipped.
  - Vector beats write `fill_byte` replicated 24 times; scalar beats write {184'b0, `fill_byte`}.
  - Each beat is 1 cycle (VWR/SWR only); `src_addr` is ignored.
- **When undefined**
  - Ports are absent and every transfer is a copy.

Test Plan:
- READ_LAT=1; start with `src_addr`=1000, `dst_addr`=31000, `len_bytes`=48 -> vector reads at 1000 and 1024, vector writes at 31000 and 31024.
  - Writes occur in cycles 3 and 6 after the start edge; `done`=1, `err`=0 in cycle 7.
  - `mem_wd` equals the source vectors.
- `len_bytes`=26, `src_addr`=1000, `dst_addr`=31005 -> one vector write at 31005, then scalar writes at 31029 and 31030 with `mem_vecop`=0.
  - `done` occurs in cycle 10.
- `len_bytes`=0 -> `done`=1, `err`=0 in cycle 1; `dst_addr`=500, `len_bytes`=24 -> `done`=1, `err`=1 in cycle 1; no `mem_we` in either case.
- `start` pulsed again in cycle 2 of a 48-byte copy with different addresses -> ignored; the original transfer completes unchanged.
- `rst` asserted in cycle 4 of a 48-byte copy -> all outputs 0 next cycle, no `done`, no second write; a fresh `start` then works normally.
- With `BLKCOPY_FILL_EN` defined, `fill`=1, `fill_byte`=8'hA5, `len_bytes`=25, `dst_addr`=31000:
  - Writes at 31000 (24 x A5) in cycle 1 and 31024 (A5) in cycle 2.
  - No read cycles; `done` in cycle 3.

Source files
------------

// File: rtl/mem_block_copier.sv
// Copies a byte range into RAM over the memoryController data port.
// The bulk moves as vector beats and the tail moves as scalar bytes.
// Define BLKCOPY_FILL_EN to add the fill mode, which writes fill_byte and skips all reads.

module mem_block_copier_lane (
  input  logic       lane_en,
  input  logic       fill,
  input  logic [7:0] buf_byte,
  input  logic [7:0] fill_byte,
  output logic [7:0] wd_byte
);
  assign wd_byte = !lane_en ? 8'h00 : (fill ? fill_byte : buf_byte);
endmodule

module mem_block_copier #(
  parameter int DATA_W    = 192,
  parameter int VEC_BYTES = 24,
  parameter int RAM_BASE  = 31000,
  parameter int READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [15:0]       len_bytes,
`ifdef BLKCOPY_FILL_EN
  input  logic              fill,
  input  logic [7:0]        fill_byte,
`endif
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_we,
  output logic              mem_vecop,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {IDLE, VRD, VWAIT, VWR, SRD, SWAIT, SWR, DONE} state_t;

  state_t                       state, state_nxt;
  logic [31:0]                  src_ptr, dst_ptr;
  logic [15:0]                  remain;
  logic                         err_q;
  logic [CW-1:0]                wait_cnt;
  logic [VEC_BYTES-1:0][7:0]    beat_buf;
  logic [VEC_BYTES-1:0][7:0]    wd_lanes;
  logic                         fill_in, fill_q;
  logic [7:0]                   fill_byte_q;
  logic                         rd_st, wr_vec, wr_scl;

`ifdef BLKCOPY_FILL_EN
  assign fill_in = fill;
`else
  assign fill_in     = 1'b0;
  assign fill_q      = 1'b0;
  assign fill_byte_q = 8'h00;
`endif

  // Fill beats have nothing to read, so they jump straight to the write state.
  function automatic state_t beat_sel(input logic [15:0] rem, input logic fl);
    if (rem >= 16'(VEC_BYTES)) return fl ? VWR : VRD;
    else if (rem != 16'd0)     return fl ? SWR : SRD;
    else                       return DONE;
  endfunction

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) begin
        if (len_bytes == 16'd0)              state_nxt = DONE;
        else if (dst_addr < 32'(RAM_BASE))   state_nxt = DONE;
        else                                 state_nxt = beat_sel(len_bytes, fill_in);
      end
      VRD:   state_nxt = VWAIT;
      VWAIT: if (wait_cnt == '0) state_nxt = VWR;
      VWR:   state_nxt = beat_sel(remain - 16'(VEC_BYTES), fill_q);
      SRD:   state_nxt = SWAIT;
      SWAIT: if (wait_cnt == '0) state_nxt = SWR;
      SWR:   state_nxt = beat_sel(remain - 16'd1, fill_q);
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      src_ptr  <= '0;
      dst_ptr  <= '0;
      remain   <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
      beat_buf <= '0;
`ifdef BLKCOPY_FILL_EN
      fill_q      <= 1'b0;
      fill_byte_q <= 8'h00;
`endif
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (start) begin
          src_ptr <= src_addr;
          dst_ptr <= dst_addr;
          remain  <= len_bytes;
          // An empty request is a clean no-op even if the destination is illegal.
          err_q   <= (len_bytes != 16'd0) && (dst_addr < 32'(RAM_BASE));
`ifdef BLKCOPY_FILL_EN
          fill_q      <= fill;
          fill_byte_q <= fill_byte;
`endif
        end
        VRD, SRD: wait_cnt <= CW'(READ_LAT - 1);
        VWAIT: begin
          if (wait_cnt == '0) beat_buf <= mem_rd;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        SWAIT: begin
          if (wait_cnt == '0) beat_buf <= DATA_W'(mem_rd[7:0]);
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        VWR: begin
          src_ptr <= src_ptr + 32'(VEC_BYTES);
          dst_ptr <= dst_ptr + 32'(VEC_BYTES);
          remain  <= remain - 16'(VEC_BYTES);
        end
        SWR: begin
          src_ptr <= src_ptr + 32'd1;
          dst_ptr <= dst_ptr + 32'd1;
          remain  <= remain - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign rd_st  = (state == VRD) || (state == VWAIT) || (state == SRD) || (state == SWAIT);
  assign wr_vec = (state == VWR);
  assign wr_scl = (state == SWR);

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign err         = done && err_q;
  assign mem_we      = wr_vec || wr_scl;
  assign mem_vecop   = (state == VRD) || (state == VWAIT) || wr_vec;
  assign mem_address = rd_st ? src_ptr : (mem_we ? dst_ptr : 32'd0);

  // Write data is built per byte lane; only lane 0 is live on a scalar beat.
  for (genvar i = 0; i < VEC_BYTES; i++) begin : g_lane
    localparam bit LANE0 = (i == 0);
    mem_block_copier_lane u_lane (
      .lane_en   (wr_vec || (wr_scl && LANE0)),
      .fill      (fill_q),
      .buf_byte  (beat_buf[i]),
      .fill_byte (fill_byte_q),
      .wd_byte   (wd_lanes[i])
    );
  end

  assign mem_wd = wd_lanes;

endmodule

// File: tb/tb_mem_block_copier.sv
// Directed bench for mem_block_copier with a memory model and a write scoreboard.
// Expected writes and completion cycles are queued from the request, then checked as the DUT acts.

module tb_mem_block_copier;

  localparam int LAT = 1;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        vec;
    logic [191:0] wd;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  src_addr = '0, dst_addr = '0;
  logic [15:0]  len_bytes = '0;
`ifdef BLKCOPY_FILL_EN
  logic         fill = 1'b0;
  logic [7:0]   fill_byte = 8'h00;
`endif
  logic         busy, done, err, mem_we, mem_vecop;
  logic [31:0]  mem_address;
  logic [191:0] mem_wd;
  logic [191:0] mem_rd = '0;

  int  checks = 0;
  int  failures = 0;
  wr_t exp_q[$];

  mem_block_copier #(.READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_bytes(len_bytes),
`ifdef BLKCOPY_FILL_EN
    .fill(fill), .fill_byte(fill_byte),
`endif
    .busy(busy), .done(done), .err(err),
    .mem_we(mem_we), .mem_vecop(mem_vecop), .mem_address(mem_address),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] src_byte(input logic [31:0] a);
    return 8'(a * 32'd37 + 32'd11);
  endfunction

  function automatic logic [191:0] rd_vec(input logic [31:0] a);
    logic [191:0] v;
    for (int i = 0; i < 24; i++) v[i*8 +: 8] = src_byte(a + 32'(i));
    return v;
  endfunction

  // Read port with one cycle of latency; scalar reads also see the full line.
  always @(posedge clk) mem_rd <= rd_vec(mem_address);

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] n, output int done_cyc);
    int c = 0;
    while (n != 0) begin
      c += LAT + 2;
      if (n >= 16'd24) begin
        exp_q.push_back('{c, d, 1'b1, rd_vec(s)});
        s += 32'd24; d += 32'd24; n -= 16'd24;
      end else begin
        exp_q.push_back('{c, d, 1'b0, {184'b0, src_byte(s)}});
        s += 32'd1; d += 32'd1; n -= 16'd1;
      end
    end
    done_cyc = c + 1;
  endtask

  // poke_kind: 0 none, 1 extra start pulse, 2 reset pulse (both in cycle poke_cyc)
  task automatic run(input string nm, input logic [31:0] s, input logic [31:0] d,
                     input logic [15:0] n, input int exp_done, input logic exp_err,
                     input int poke_kind, input int poke_cyc, input int maxc);
    bit got_done = 0;
    wr_t e;
    @(negedge clk);
    src_addr = s; dst_addr = d; len_bytes = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      chk({nm, "_busy"}, busy, 1'(!(poke_kind == 2 && k > poke_cyc)));
      if (poke_kind == 2 && k == poke_cyc + 1)
        chk({nm, "_rst_outs"}, {busy, done, err, mem_we, mem_vecop, mem_address, mem_wd[31:0]}, '0);
      if (!done) chk({nm, "_err_nodone"}, err, 0);
      if (mem_we) begin
        chk({nm, "_wr_expected"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk({nm, "_wr_cyc"}, k, e.cyc);
          chk({nm, "_wr_addr"}, mem_address, e.addr);
          chk({nm, "_wr_vec"}, mem_vecop, e.vec);
          chk({nm, "_wr_data"}, mem_wd, e.wd);
        end
      end
      if (done) begin
        chk({nm, "_done_cyc"}, k, exp_done);
        chk({nm, "_err"}, err, exp_err);
        chk({nm, "_done_bus"}, {mem_we, mem_vecop, mem_address, mem_wd}, '0);
        got_done = 1;
        break;
      end
      if (poke_kind == 1 && k == poke_cyc) begin
        src_addr = 32'd5000; dst_addr = 32'd40000; len_bytes = 16'd24; start = 1'b1;
      end
      if (poke_kind == 2 && k == poke_cyc) rst = 1'b1;
    end
    start = 1'b0; rst = 1'b0;
    if (exp_done > 0) chk({nm, "_done_seen"}, got_done, 1);
    chk({nm, "_q_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int dc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {busy, done, err, mem_we, mem_vecop, mem_address, mem_wd}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", {busy, done, err, mem_we, mem_vecop, mem_address, mem_wd}, '0);

    push_copy(32'd1000, 32'd31000, 16'd48, dc);
    chk("model_48_done", dc, 7);
    run("vec48", 32'd1000, 32'd31000, 16'd48, dc, 1'b0, 0, 0, 20);

    push_copy(32'd1000, 32'd31005, 16'd26, dc);
    chk("model_26_done", dc, 10);
    run("mix26", 32'd1000, 32'd31005, 16'd26, dc, 1'b0, 0, 0, 20);

    run("len0", 32'd1000, 32'd31000, 16'd0, 1, 1'b0, 0, 0, 5);
    run("lowdst", 32'd1000, 32'd500, 16'd24, 1, 1'b1, 0, 0, 5);
    run("dst30999", 32'd1000, 32'd30999, 16'd1, 1, 1'b1, 0, 0, 5);
    run("len0_lowdst", 32'd1000, 32'd500, 16'd0, 1, 1'b0, 0, 0, 5);

    push_copy(32'd2000, 32'd31000, 16'd24, dc);
    run("vec24", 32'd2000, 32'd31000, 16'd24, dc, 1'b0, 0, 0, 10);

    push_copy(32'd2001, 32'd33333, 16'd3, dc);
    run("scl3", 32'd2001, 32'd33333, 16'd3, dc, 1'b0, 0, 0, 15);

    push_copy(32'hFFFF_FFF0, 32'hFFFF_FFF8, 16'd26, dc);
    run("wrap", 32'hFFFF_FFF0, 32'hFFFF_FFF8, 16'd26, dc, 1'b0, 0, 0, 20);

    push_copy(32'd3000, 32'd32000, 16'd48, dc);
    run("restart", 32'd3000, 32'd32000, 16'd48, dc, 1'b0, 1, 2, 20);

    push_copy(32'd1000, 32'd31000, 16'd48, dc);
    void'(exp_q.pop_back());
    run("rst_mid", 32'd1000, 32'd31000, 16'd48, 0, 1'b0, 2, 4, 12);

    push_copy(32'd1000, 32'd31000, 16'd48, dc);
    run("after_rst", 32'd1000, 32'd31000, 16'd48, dc, 1'b0, 0, 0, 20);

`ifdef BLKCOPY_FILL_EN
    fill = 1'b1; fill_byte = 8'hA5;
    exp_q.push_back('{1, 32'd31000, 1'b1, {24{8'hA5}}});
    exp_q.push_back('{2, 32'd31024, 1'b0, {184'b0, 8'hA5}});
    run("fill25", 32'd7, 32'd31000, 16'd25, 3, 1'b0, 0, 0, 10);
    fill = 1'b0;
`endif

    @(negedge clk);
    chk("final_idle", {busy, mem_we, mem_address}, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
